// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: request/response link types shared by the cores, the interconnect
// and the memory responder.
package mem_responder_pkg;
    localparam int NUM_OF_CORES = 4;
    localparam int ADDR_WIDTH   = 16;
    localparam int DATA_WIDTH   = 32;
    localparam int LEN_WIDTH    = 2 * NUM_OF_CORES;

    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_RSP_DATA, OP_WR_ACK} opcode_t;

    typedef struct packed {
        logic                  vld;
        opcode_t               opcode;
        logic [3:0]            core_id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [LEN_WIDTH-1:0]  access_length;
    } request_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push while full is taken only when a pop frees a slot
// in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             wr_en, rd_en;

    // extra pointer MSB tells a full ring from an empty one
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = slots[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end

    always_ff @(posedge clk)
        if (wr_en) slots[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side link endpoint; queues requests, serves reads as bursts and
// writes with a single acknowledge, tagging every response with the requesting core.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH      = 1024,
    parameter int REQ_FIFO_DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    input  request_t mem_req,
    output request_t mem_rsp,
    output logic     req_fifo_full,
    output logic     req_overflow,
    output logic     busy
);
    localparam int IW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, READ_BURST, WRITE_ACK} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    request_t              head, wr_req, beat, ack;
    logic [3:0]            cur_core;
    logic [IW-1:0]         cur_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  fifo_empty, pop;

    sync_fifo #(
        .WIDTH($bits(request_t)),
        .DEPTH(REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clk  (clk),
        .reset(reset),
        .push (mem_req.vld),
        .pop  (pop),
        .din  (mem_req),
        .full (req_fifo_full),
        .empty(fifo_empty),
        .dout (head)
    );

    // the last beat of a burst doubles as an IDLE cycle so bursts run back to back
    assign pop  = !fifo_empty && (state != READ_BURST || remaining == LEN_WIDTH'(1));
    assign busy = state != IDLE || !fifo_empty;

    always_comb begin
        beat               = '0;
        beat.vld           = 1'b1;
        beat.opcode        = OP_RSP_DATA;
        beat.core_id       = cur_core;
        beat.addr          = ADDR_WIDTH'(cur_addr);
        beat.data          = mem[cur_addr];
        beat.access_length = remaining;
        ack                = wr_req;
        ack.vld            = 1'b1;
        ack.opcode         = OP_WR_ACK;
        ack.access_length  = LEN_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state        <= IDLE;
            mem_rsp      <= '0;
            wr_req       <= '0;
            cur_core     <= '0;
            cur_addr     <= '0;
            remaining    <= '0;
            req_overflow <= 1'b0;
        end else begin
            if (mem_req.vld && req_fifo_full && !pop) req_overflow <= 1'b1;
            mem_rsp <= '0;
            if (state == READ_BURST) begin
                mem_rsp   <= beat;
                cur_addr  <= cur_addr + IW'(1);
                remaining <= remaining - LEN_WIDTH'(1);
            end
            if (state == WRITE_ACK) mem_rsp <= ack;
            if (pop) begin
                state     <= head.opcode == OP_READ ? READ_BURST :
                             head.opcode == OP_WRITE ? WRITE_ACK : IDLE;
                cur_core  <= head.core_id;
                cur_addr  <= head.addr[IW-1:0];
                remaining <= head.access_length == '0 ? LEN_WIDTH'(1) : head.access_length;
                wr_req    <= head;
            end else if (state != READ_BURST || remaining == LEN_WIDTH'(1)) begin
                state <= IDLE;
            end
        end

    always_ff @(posedge clk)
        if (pop && head.opcode == OP_WRITE) mem[head.addr[IW-1:0]] <= head.data;
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side endpoint of the core/memory request_t link.
- Accepts single-cycle request pulses from the interconnect on mem_req and buffers them in a request FIFO, because the link has no backpressure.
- Services each request against an internal word-addressed memory array.
- Returns responses on mem_rsp, tagged with the originating core_id so the interconnect can route them back.

Parameters:
MEM_DEPTH, 1024, number of DATA_WIDTH words in the array (power of 2)
REQ_FIFO_DEPTH, 8, request FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock
reset  input  1  asynchronous reset, active-high
mem_req  input  request_t  request from interconnect; consumed only when mem_req.vld=1
mem_rsp  output  request_t  response to interconnect, registered; one beat per cycle while mem_rsp.vld=1
req_fifo_full  output  1  request FIFO holds REQ_FIFO_DEPTH entries
req_overflow  output  1  sticky; a request was dropped
busy  output  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- request_t fields used: vld, opcode (OP_READ/OP_WRITE/OP_RSP_DATA/OP_WR_ACK), core_id[3:0], addr[ADDR_WIDTH-1:0], data[DATA_WIDTH-1:0], access_length[2*NUM_OF_CORES-1:0].
- Reset: mem_rsp='0, req_fifo_full=0, req_overflow=0, busy=0, FIFO emptied, FSM=IDLE. Memory array contents are not reset.
- Push: mem_req.vld=1 pushes the whole struct.
  - If the FIFO is full and no pop occurs that cycle, the request is dropped and req_overflow sets (cleared only by reset).
  - Full with a simultaneous pop: the push is accepted.
- FSM states IDLE, READ_BURST, WRITE_ACK.
  - IDLE: if FIFO not empty, pop the head.
    - OP_READ: latch core_id, base addr, beats = (access_length==0 ? 1 : access_length); go to READ_BURST.
    - OP_WRITE: write data to mem[addr mod MEM_DEPTH] this cycle; go to WRITE_ACK.
    - Any other opcode: discard; stay IDLE with no response.
  - READ_BURST: each cycle issue one beat.
    - Beat contents: mem_rsp.vld=1, opcode=OP_RSP_DATA, core_id=latched, addr=(base+k) mod MEM_DEPTH, data=mem[that addr], access_length=remaining beats including this one.
    - After the last beat return to IDLE. No idle cycle is inserted between back-to-back requests: the next pop occurs in the cycle the last beat is registered.
  - WRITE_ACK: one beat with vld=1, opcode=OP_WR_ACK, core_id, addr, data echoed, access_length=1; return to IDLE, popping the next request in the same cycle if available.
- mem_rsp is '0 in any cycle without a beat.
- Latency with FSM idle and FIFO empty: request at edge T; popped at T+1; first response beat registered at T+2. A read of N beats occupies T+2..T+N+1. Write data is visible to any read popped from T+2 onward.
- Address arithmetic wraps modulo MEM_DEPTH; a burst crossing the top address continues at 0.
- Reads use the combinational array value at the beat's address; the array is written only in IDLE on an OP_WRITE pop, so there is no read/write hazard within a burst.
- FIFO pointers are log2(REQ_FIFO_DEPTH)+1 bits. Full when MSBs differ and the low bits are equal; empty when all bits are equal.
- Reset asserted mid-burst aborts the burst immediately: mem_rsp is '0 from the reset edge and queued requests are lost.

Decomposition:
- Shared package: request_t, NUM_OF_CORES, ADDR_WIDTH, DATA_WIDTH, and the opcode enum (OP_READ, OP_WRITE, OP_RSP_DATA, OP_WR_ACK).
- Local to the block: the FSM state enum.
- One sub-module: sync_fifo, parameterised on payload width and depth. It provides push, pop, full, empty and dout, and handles full with simultaneous push and pop as above. The block instantiates it for request_t.

Test Plan:
- Write then read: OP_WRITE core 2, addr 0x10, data 0xA5A5 at T; OP_READ core 2, addr 0x10, length 1 at T+1 -> OP_WR_ACK core_id=2 at T+2; OP_RSP_DATA data=0xA5A5 core_id=2 at T+3.
- Burst with wrap: mem preloaded with mem[i]=i; OP_READ addr MEM_DEPTH-2, length 4, core 1 -> 4 consecutive beats, addr 1022,1023,0,1, data 1022,1023,0,1, access_length 4,3,2,1, core_id=1.
- Length zero: OP_READ access_length=0 -> exactly one beat, then mem_rsp='0.
- Back-to-back interleaving: cores 0..3 each issue OP_READ length 2 on consecutive cycles -> 8 contiguous beats, core_id order 0,0,1,1,2,2,3,3, no gap beats.
- Overflow: stall FSM with OP_READ length 255, then push REQ_FIFO_DEPTH+1 requests -> req_fifo_full=1 after 8 pushes, 9th dropped, req_overflow=1 and stays high; the 8 queued requests are later served in order.
- Reset mid-burst: assert reset during beat 3 of a length-10 read -> mem_rsp='0, busy=0, req_overflow=0 immediately. After release, a read of a previously written address returns the written data, since memory is retained.
